// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman feeder slice: base codes, score
// width default, biased-zero helper and the one-hot feeder state encoding.
package sw_pkg;

  localparam logic [1:0] _A = 2'b00;
  localparam logic [1:0] _G = 2'b01;
  localparam logic [1:0] _T = 2'b10;
  localparam logic [1:0] _C = 2'b11;

  localparam int SCORE_WIDTH_DEFAULT = 12;

  localparam int IDLE_BIT   = 0;
  localparam int STREAM_BIT = 1;
  localparam int DRAIN_BIT  = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001 << IDLE_BIT,
    S_STREAM = 3'b001 << STREAM_BIT,
    S_DRAIN  = 3'b001 << DRAIN_BIT
  } state_t;

  // Scores are offset-binary: the mid-code of the width represents zero.
  function automatic logic [31:0] zero_of(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sw_target_feeder_if.sv
// Valid/ready stream carrying target bases into the feeder.
interface sw_target_feeder_if;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] s_base;
  logic       s_last;

  modport master (output s_valid, output s_base, output s_last, input s_ready);
  modport slave  (input s_valid, input s_base, input s_last, output s_ready);
endinterface

// File: rtl/sw_base_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags and occupancy.
module sw_base_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sw_target_feeder.sv
// Head-of-array feeder: buffers target bases and streams each sequence into PE0.
// Define SW_FEEDER_TIMEOUT_EN to add a drain watchdog of TIMEOUT cycles.
module sw_target_feeder
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = SCORE_WIDTH_DEFAULT,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  sw_target_feeder_if.slave      up,
  output logic                   en_out,
  output logic [1:0]             data_out,
  output logic [SCORE_WIDTH-1:0] M_out,
  output logic [SCORE_WIDTH-1:0] I_out,
  output logic [SCORE_WIDTH-1:0] High_out,
  input  logic                   done_in,
  output logic                   busy,
  output logic                   seq_done,
  output logic                   err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(zero_of(SCORE_WIDTH));

  state_t        state_q, state_d;
  logic          push, pop;
  logic [2:0]    head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] seq_cnt;
  logic          en_d, seq_done_d, err_d;
  logic [1:0]    data_d;

`ifdef SW_FEEDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
`endif

  assign up.s_ready = (fifo_count != CW'(DEPTH));
  assign push       = up.s_valid && up.s_ready;
  assign busy       = (state_q != S_IDLE);

  sw_base_fifo #(
    .WIDTH (3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({up.s_last, up.s_base}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    en_d       = 1'b0;
    data_d     = _A;
    seq_done_d = 1'b0;
    err_d      = 1'b0;
`ifdef SW_FEEDER_TIMEOUT_EN
    wd_d       = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (seq_cnt != '0) begin
          state_d = S_STREAM;
        end else if (fifo_full) begin
          // Buffer filled without a terminator: stream what we have and flag it.
          state_d = S_STREAM;
          err_d   = 1'b1;
        end
      end
      S_STREAM: begin
        if (fifo_empty) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else begin
          pop    = 1'b1;
          en_d   = 1'b1;
          data_d = head[1:0];
          if (head[2]) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (done_in) begin
          seq_done_d = 1'b1;
          state_d    = S_IDLE;
        end
`ifdef SW_FEEDER_TIMEOUT_EN
        else if (wd_q == WW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SW_FEEDER_TIMEOUT_EN
    if (state_d == S_DRAIN && state_q != S_DRAIN) wd_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      seq_cnt  <= '0;
      en_out   <= 1'b0;
      data_out <= _A;
      seq_done <= 1'b0;
      err      <= 1'b0;
      M_out    <= ZERO;
      I_out    <= ZERO;
      High_out <= ZERO;
`ifdef SW_FEEDER_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      en_out   <= en_d;
      data_out <= data_d;
      seq_done <= seq_done_d;
      err      <= err_d;
      M_out    <= ZERO;
      I_out    <= ZERO;
      High_out <= ZERO;
`ifdef SW_FEEDER_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
      // Number of complete sequences waiting in the buffer.
      case ({push && up.s_last, pop && head[2]})
        2'b10:   seq_cnt <= seq_cnt + 1'b1;
        2'b01:   seq_cnt <= seq_cnt - 1'b1;
        default: seq_cnt <= seq_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_target_feeder.sv
// Self-checking bench for sw_target_feeder: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based behavioural model.
module tb_sw_target_feeder;
  localparam int SW      = 12;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int ZERO_V  = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          done_in = 1'b0;
  logic          en_out;
  logic [1:0]    data_out;
  logic [SW-1:0] M_out, I_out, High_out;
  logic          busy, seq_done, err;

  sw_target_feeder_if bus ();

  sw_target_feeder #(
    .SCORE_WIDTH (SW),
    .DEPTH       (DEPTH),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .up       (bus),
    .en_out   (en_out),
    .data_out (data_out),
    .M_out    (M_out),
    .I_out    (I_out),
    .High_out (High_out),
    .done_in  (done_in),
    .busy     (busy),
    .seq_done (seq_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_STREAM, M_DRAIN} mstate_t;
  mstate_t    mst = M_IDLE;
  logic [2:0] q[$];
  int         drain_cycles = 0;
  logic       exp_en = 0, exp_sd = 0, exp_err = 0;
  logic [1:0] exp_data = 0;

  function automatic int lasts_buffered();
    int n = 0;
    foreach (q[i]) if (q[i][2]) n++;
    return n;
  endfunction

  task automatic model_step();
    logic [2:0] e;
    bit full, empty, do_push;
    if (!rst) begin
      q.delete();
      mst = M_IDLE;
      exp_en = 0; exp_data = 0; exp_sd = 0; exp_err = 0;
      return;
    end
    full    = (q.size() == DEPTH);
    empty   = (q.size() == 0);
    do_push = bus.s_valid && !full;
    exp_en = 0; exp_data = 0; exp_sd = 0; exp_err = 0;
    case (mst)
      M_IDLE: begin
        if (lasts_buffered() > 0) mst = M_STREAM;
        else if (full) begin mst = M_STREAM; exp_err = 1; end
      end
      M_STREAM: begin
        if (empty) begin
          exp_err = 1; mst = M_DRAIN; drain_cycles = 0;
        end else begin
          e = q.pop_front();
          exp_en = 1; exp_data = e[1:0];
          if (e[2]) begin mst = M_DRAIN; drain_cycles = 0; end
        end
      end
      default: begin
        if (done_in) begin exp_sd = 1; mst = M_IDLE; end
`ifdef SW_FEEDER_TIMEOUT_EN
        else begin
          drain_cycles++;
          if (drain_cycles == TIMEOUT) begin exp_err = 1; mst = M_IDLE; end
        end
`endif
      end
    endcase
    if (do_push) q.push_back({bus.s_last, bus.s_base});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare + burst monitor ----------------
  int         bursts[$];
  int         gaps[$];
  logic [1:0] data_log[$];
  logic [1:0] sent[$];
  int         cur_len = 0, low_run = 0, sd_count = 0, err_count = 0;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("en_out",   en_out,   exp_en);
      check("data_out", data_out, exp_data);
      check("seq_done", seq_done, exp_sd);
      check("err",      err,      exp_err);
      check("busy",     busy,     mst != M_IDLE);
      check("s_ready",  bus.s_ready, q.size() < DEPTH);
      check("M_out",    M_out,    ZERO_V);
      check("I_out",    I_out,    ZERO_V);
      check("High_out", High_out, ZERO_V);
      if (en_out === 1'b1) begin
        if (cur_len == 0) gaps.push_back(low_run);
        cur_len++; low_run = 0;
        data_log.push_back(data_out);
      end else begin
        if (cur_len > 0) begin bursts.push_back(cur_len); cur_len = 0; end
        low_run++;
      end
      if (seq_done === 1'b1) sd_count++;
      if (err === 1'b1) err_count++;
    end
  end

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic clear_mon();
    bursts.delete(); gaps.delete(); data_log.delete(); sent.delete();
    sd_count = 0; err_count = 0;
  endtask

  task automatic send(input logic [1:0] b, input bit last);
    int t = 0;
    bus.s_valid = 1'b1; bus.s_base = b; bus.s_last = last;
    while (bus.s_ready !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    if (t == 500) check("send_accept_timeout", bus.s_ready, 1);
    sent.push_back(b);
    @(negedge clk);
  endtask

  task automatic stop_send();
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic wait_en(input logic level, input string what);
    int t = 0;
    while (en_out !== level && t < 300) begin @(negedge clk); t++; end
    if (t == 300) check(what, en_out, level);
  endtask

  task automatic pulse_done(input int delay);
    repeat (delay) @(negedge clk);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
  endtask

  task automatic check_log(input string name);
    check({name, " beat count"}, data_log.size(), sent.size());
    foreach (sent[i]) if (i < data_log.size()) check({name, " data"}, data_log[i], sent[i]);
  endtask

  bit stop_rand;

  initial begin
    bus.s_valid = 1'b0; bus.s_base = 2'b00; bus.s_last = 1'b0;
    repeat (3) @(negedge clk);
    check("reset en_out", en_out, 0);
    check("reset s_ready", bus.s_ready, 1);
    check("reset M_out", M_out, 12'h800);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single sequence A,G,T,C
    clear_mon();
    send(2'b00, 0); send(2'b01, 0); send(2'b10, 0); send(2'b11, 1); stop_send();
    wait_en(1, "t1 burst start"); wait_en(0, "t1 burst end");
    pulse_done(10);
    repeat (3) @(negedge clk);
    check("t1 burst count", bursts.size(), 1);
    check("t1 burst len", bursts.size() > 0 ? bursts[0] : 0, 4);
    for (int i = 0; i < 4; i++) check("t1 data literal", i < data_log.size() ? data_log[i] : 2'bxx, i);
    check("t1 seq_done pulses", sd_count, 1);
    check("t1 busy after", busy, 0);

    // Back-to-back 3-base sequences
    clear_mon();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 3; k++) send(2'($urandom_range(0, 3)), k == 2);
    stop_send();
    wait_en(1, "t2 b1 start"); wait_en(0, "t2 b1 end"); pulse_done(4);
    wait_en(1, "t2 b2 start"); wait_en(0, "t2 b2 end"); pulse_done(2);
    repeat (3) @(negedge clk);
    check("t2 burst count", bursts.size(), 2);
    check("t2 burst0 len", bursts.size() > 0 ? bursts[0] : 0, 3);
    check("t2 burst1 len", bursts.size() > 1 ? bursts[1] : 0, 3);
    check("t2 gap at least 2", gaps.size() > 1 && gaps[1] >= 2, 1);
    check_log("t2");

    // Overlong: 16 bases without a terminator
    clear_mon();
    for (int k = 0; k < DEPTH; k++) send(2'($urandom_range(0, 3)), 0);
    stop_send();
    wait_en(1, "t3 burst start"); wait_en(0, "t3 burst end");
    repeat (2) @(negedge clk);
    pulse_done(3);
    repeat (3) @(negedge clk);
    check("t3 burst len", bursts.size() > 0 ? bursts[0] : 0, 16);
    check("t3 err pulses", err_count, 2);
    check("t3 seq_done pulses", sd_count, 1);
    check_log("t3");

    // Concurrent push/pop: valid held high while streaming
    clear_mon();
    fork
      begin
        for (int k = 0; k < 12; k++) send(2'($urandom_range(0, 3)), k == 11);
        for (int k = 0; k < 8; k++)  send(2'($urandom_range(0, 3)), k == 7);
        for (int k = 0; k < 5; k++)  send(2'($urandom_range(0, 3)), k == 4);
        stop_send();
      end
      begin
        for (int b = 0; b < 3; b++) begin
          wait_en(1, "t4 burst start"); wait_en(0, "t4 burst end");
          pulse_done($urandom_range(1, 5));
        end
      end
    join
    repeat (3) @(negedge clk);
    check("t4 burst0 len", bursts.size() > 0 ? bursts[0] : 0, 12);
    check("t4 burst1 len", bursts.size() > 1 ? bursts[1] : 0, 8);
    check("t4 burst2 len", bursts.size() > 2 ? bursts[2] : 0, 5);
    check_log("t4");

    // Reset during the second base of a 5-base burst
    for (int k = 0; k < 5; k++) send(2'($urandom_range(0, 3)), k == 4);
    stop_send();
    wait_en(1, "t5 burst start");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t5 en_out after reset", en_out, 0);
    check("t5 s_ready after reset", bus.s_ready, 1);
    check("t5 busy after reset", busy, 0);
    @(negedge clk);
    clear_mon();
    for (int k = 0; k < 3; k++) send(2'($urandom_range(0, 3)), k == 2);
    stop_send();
    wait_en(1, "t5b burst start"); wait_en(0, "t5b burst end");
    pulse_done(2);
    repeat (3) @(negedge clk);
    check("t5 next burst len", bursts.size() > 0 ? bursts[0] : 0, 3);
    check_log("t5");

`ifdef SW_FEEDER_TIMEOUT_EN
    // Drain watchdog: no done_in at all
    clear_mon();
    send(2'b10, 0); send(2'b01, 1); stop_send();
    wait_en(1, "t6 burst start"); wait_en(0, "t6 burst end");
    repeat (TIMEOUT + 4) @(negedge clk);
    check("t6 timeout err", err_count, 1);
    check("t6 no seq_done", sd_count, 0);
    check("t6 busy after timeout", busy, 0);
`endif

    // Randomized traffic with random done_in noise
    stop_rand = 0;
    fork
      begin
        for (int s = 0; s < 40; s++) begin
          int len;
          len = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH + 1, DEPTH + 6)
                                           : $urandom_range(1, DEPTH);
          for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) begin
              stop_send();
              repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send(2'($urandom_range(0, 3)), k == len - 1);
          end
        end
        stop_send();
        for (int t = 0; t < 3000 && (q.size() != 0 || mst != M_IDLE); t++) @(negedge clk);
        check("random drain complete", q.size(), 0);
        stop_rand = 1;
      end
      begin
        while (!stop_rand) begin
          @(negedge clk);
          done_in = ($urandom_range(0, 5) == 0);
        end
        done_in = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("final busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
